// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_pkg
// Purpose  : Definitions shared by the core control FSM and the memory
//            controller. Holds the data-condition codes, the default
//            data-path sizes, and a helper that maps the condition input
//            onto a legal code.
// Revision : 1.0  initial release
// ============================================================================
package core_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_ADDR_W    = 6;
    localparam int DEF_REG_WORDS = 4;

    typedef logic [2:0] cond_t;

    localparam cond_t COND_IDLE  = 3'b000;
    localparam cond_t COND_STORE = 3'b100;
    localparam cond_t COND_TRANS = 3'b010;
    localparam cond_t COND_PROC  = 3'b001;

    // Multi-bit (illegal) codes behave exactly like idle.
    function automatic cond_t cond_sanitize(input cond_t raw);
        case (raw)
            COND_STORE, COND_TRANS, COND_PROC: return raw;
            default:                           return COND_IDLE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_sram.sv
`default_nettype none
// ============================================================================
// Module   : mc_sram
// Purpose  : Single-port synchronous RAM with one-cycle read latency.
//            The array has no reset. On a write cycle the read data is
//            not meaningful.
// Ports    : ctrl_clk  clock
//            we        write enable
//            addr      word address
//            wdata     write data
//            rdata     registered read data for the address of the
//                      previous cycle
// Revision : 1.0  initial release
// ============================================================================
module mc_sram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              ctrl_clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge ctrl_clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule
`default_nettype wire

// File: rtl/memory_controller.sv
`default_nettype none
// ============================================================================
// Module   : memory_controller
// Purpose  : Stores an input block into on-chip RAM under condition 100,
//            then moves it into the register window REG_WORDS words at a
//            time under condition 010. An operation starts only on a change
//            of the (sanitised) condition code. Any other change aborts to
//            IDLE.
// Ports    : ctrl_clk, ctrl_reset   clock, async active-high reset
//            ctrl_data_contition    condition code (100/010/001/000)
//            data_in, data_in_valid input stream
//            data_in_length         block length, sampled at store start
//            mc_done                one-cycle end-of-operation pulse
//            mc_data_done           level: whole block transferred
//            reg_data_out           register window, word 0 in the LSBs
//            reg_valid              window holds a completed load
// Revision : 1.0  initial release
// ============================================================================
module memory_controller
    import core_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DEPTH     = 1 << DEF_ADDR_W,
    parameter int REG_WORDS = DEF_REG_WORDS
) (
    input  logic                        ctrl_clk,
    input  logic                        ctrl_reset,
    input  logic [2:0]                  ctrl_data_contition,
    input  logic [DATA_W-1:0]           data_in,
    input  logic                        data_in_valid,
    input  logic [ADDR_W:0]             data_in_length,
    output logic                        mc_done,
    output logic                        mc_data_done,
    output logic [REG_WORDS*DATA_W-1:0] reg_data_out,
    output logic                        reg_valid
);

    localparam int PTR_W  = ADDR_W + 1;
    localparam int CNT_W  = $clog2(REG_WORDS + 1);
    localparam int SLOT_W = (REG_WORDS > 1) ? $clog2(REG_WORDS) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_STORE = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]        state;
    cond_t             prev_cond;
    logic [PTR_W-1:0]  len;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  load_k;
    logic [CNT_W-1:0]  issue_cnt;
    logic              rd_pending;
    logic [SLOT_W-1:0] rd_slot;
    logic [DATA_W-1:0] window [REG_WORDS];

    cond_t             cond_now;
    logic              cond_changed;
    logic              start_store;
    logic              start_trans;
    logic [PTR_W-1:0]  wr_idx;
    logic [PTR_W-1:0]  wr_lim;
    logic              wr_en;
    logic [PTR_W-1:0]  remaining;
    logic [CNT_W-1:0]  next_k;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_rdata;

    assign cond_now     = cond_sanitize(ctrl_data_contition);
    assign cond_changed = (cond_now != prev_cond);
    assign start_store  = cond_changed && (cond_now == COND_STORE);
    assign start_trans  = cond_changed && (cond_now == COND_TRANS);

    // The start edge itself already writes word 0, so pointer and limit are
    // taken from the entry values on that edge.
    assign wr_idx = start_store ? '0 : wr_ptr;
    assign wr_lim = start_store ? data_in_length : len;
    assign wr_en  = data_in_valid
                 && (start_store || ((state == ST_STORE) && !cond_changed))
                 && (wr_idx < wr_lim);

    assign remaining = len - rd_ptr;
    assign next_k    = (remaining > PTR_W'(REG_WORDS)) ? CNT_W'(REG_WORDS)
                                                       : CNT_W'(remaining);

    assign rd_addr   = rd_ptr[ADDR_W-1:0] + ADDR_W'(issue_cnt);
    assign sram_addr = wr_en ? wr_idx[ADDR_W-1:0] : rd_addr;

    mc_sram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_sram (
        .ctrl_clk (ctrl_clk),
        .we       (wr_en),
        .addr     (sram_addr),
        .wdata    (data_in),
        .rdata    (sram_rdata)
    );

    always_ff @(posedge ctrl_clk or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            state        <= ST_IDLE;
            prev_cond    <= COND_IDLE;
            len          <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            load_k       <= '0;
            issue_cnt    <= '0;
            rd_pending   <= 1'b0;
            rd_slot      <= '0;
            mc_done      <= 1'b0;
            mc_data_done <= 1'b0;
            reg_valid    <= 1'b0;
            for (int i = 0; i < REG_WORDS; i++) begin
                window[i] <= '0;
            end
        end else begin
            prev_cond <= cond_now;
            mc_done   <= 1'b0;

            if (start_store) begin
                state        <= ST_STORE;
                len          <= data_in_length;
                rd_ptr       <= '0;
                mc_data_done <= 1'b0;
                reg_valid    <= 1'b0;
                rd_pending   <= 1'b0;
                wr_ptr       <= wr_en ? PTR_W'(1) : '0;
                if (data_in_length == '0) begin
                    mc_done      <= 1'b1;
                    mc_data_done <= 1'b1;
                    state        <= ST_DONE;
                end else if (wr_en && (data_in_length == PTR_W'(1))) begin
                    mc_done <= 1'b1;
                    state   <= ST_DONE;
                end
            end else if (start_trans) begin
                state      <= ST_LOAD;
                reg_valid  <= 1'b0;
                rd_pending <= 1'b0;
                issue_cnt  <= '0;
                load_k     <= next_k;
                // Clearing up front gives the zero-fill of unused slots.
                for (int i = 0; i < REG_WORDS; i++) begin
                    window[i] <= '0;
                end
                if (next_k == '0) begin
                    mc_done      <= 1'b1;
                    mc_data_done <= 1'b1;
                    state        <= ST_DONE;
                end
            end else if (cond_changed) begin
                state      <= ST_IDLE;
                rd_pending <= 1'b0;
            end else begin
                case (state)
                    ST_STORE: begin
                        if (wr_en) begin
                            wr_ptr <= wr_ptr + PTR_W'(1);
                            if (wr_ptr + PTR_W'(1) == len) begin
                                mc_done <= 1'b1;
                                state   <= ST_DONE;
                            end
                        end
                    end
                    ST_LOAD: begin
                        // rd_pending/rd_slot track the read issued one edge
                        // earlier, whose data is now on sram_rdata.
                        if (issue_cnt < load_k) begin
                            rd_pending <= 1'b1;
                            rd_slot    <= SLOT_W'(issue_cnt);
                            issue_cnt  <= issue_cnt + CNT_W'(1);
                        end else begin
                            rd_pending <= 1'b0;
                        end
                        if (rd_pending) begin
                            window[rd_slot] <= sram_rdata;
                            if (CNT_W'(rd_slot) + CNT_W'(1) == load_k) begin
                                mc_done    <= 1'b1;
                                reg_valid  <= 1'b1;
                                rd_ptr     <= rd_ptr + PTR_W'(load_k);
                                state      <= ST_DONE;
                                rd_pending <= 1'b0;
                                if (rd_ptr + PTR_W'(load_k) == len) begin
                                    mc_data_done <= 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    generate
        for (genvar g = 0; g < REG_WORDS; g++) begin : g_window
            assign reg_data_out[g*DATA_W +: DATA_W] = window[g];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_memory_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_controller
// Purpose  : Self-checking bench for memory_controller: a cycle table for
//            store/load/gapped-input sequences plus directed sequences for
//            exact multiples, edge lengths, abort, illegal code and reset.
// Revision : 1.0  initial release
// ============================================================================
module tb_memory_controller;
    import core_pkg::*;

    logic        ctrl_clk   = 1'b0;
    logic        ctrl_reset = 1'b1;
    logic [2:0]  cond       = 3'b000;
    logic        valid      = 1'b0;
    logic [7:0]  din        = 8'h00;
    logic [6:0]  dlen       = 7'd0;
    logic        mc_done;
    logic        mc_data_done;
    logic        reg_valid;
    logic [31:0] reg_data_out;

    int checks   = 0;
    int failures = 0;

    memory_controller dut (
        .ctrl_clk            (ctrl_clk),
        .ctrl_reset          (ctrl_reset),
        .ctrl_data_contition (cond),
        .data_in             (din),
        .data_in_valid       (valid),
        .data_in_length      (dlen),
        .mc_done             (mc_done),
        .mc_data_done        (mc_data_done),
        .reg_data_out        (reg_data_out),
        .reg_valid           (reg_valid)
    );

    always #5 ctrl_clk = ~ctrl_clk;

    typedef struct packed {
        logic [2:0]  c;
        logic        v;
        logic [7:0]  d;
        logic [6:0]  l;
        logic        e_done;
        logic        e_dd;
        logic        e_rv;
        logic [31:0] e_win;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge ctrl_clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] c, input logic v, input logic [7:0] d, input logic [6:0] l);
        cond  = c;
        valid = v;
        din   = d;
        dlen  = l;
    endtask

    task automatic add(input logic [2:0] c, input logic v, input logic [7:0] d, input logic [6:0] l,
                       input logic ed, input logic edd, input logic erv, input logic [31:0] ew);
        vecs.push_back({c, v, d, l, ed, edd, erv, ew});
    endtask

    // Streams n words base, base+1, ... with continuous valid.
    task automatic store_block(input int n, input logic [7:0] base, input string nm);
        if (n == 0) begin
            drive(COND_STORE, 1'b1, 8'hEE, 7'd0);
            tick;
            chk({nm, " len0 done"}, 32'(mc_done), 32'd1);
            chk({nm, " len0 data_done"}, 32'(mc_data_done), 32'd1);
        end else begin
            for (int i = 0; i < n; i++) begin
                drive(COND_STORE, 1'b1, base + 8'(i), 7'(n));
                tick;
                chk($sformatf("%s wr%0d done", nm, i), 32'(mc_done), (i == n - 1) ? 32'd1 : 32'd0);
            end
        end
        drive(COND_STORE, 1'b0, 8'h00, 7'(n));
        tick;
        chk({nm, " done drop"}, 32'(mc_done), 32'd0);
    endtask

    // One 010 phase of k words, then back to 001.
    task automatic do_load(input int k, input logic [31:0] ew, input logic edd, input string nm);
        drive(COND_TRANS, 1'b0, 8'h00, 7'd0);
        tick;
        if (k == 0) begin
            chk({nm, " k0 done"}, 32'(mc_done), 32'd1);
            chk({nm, " k0 window"}, reg_data_out, 32'd0);
            chk({nm, " k0 data_done"}, 32'(mc_data_done), 32'(edd));
        end else begin
            chk({nm, " entry done"}, 32'(mc_done), 32'd0);
            chk({nm, " entry valid"}, 32'(reg_valid), 32'd0);
            for (int i = 0; i < k; i++) begin
                tick;
                chk($sformatf("%s early done %0d", nm, i), 32'(mc_done), 32'd0);
            end
            tick;
            chk({nm, " done"}, 32'(mc_done), 32'd1);
            chk({nm, " valid"}, 32'(reg_valid), 32'd1);
            chk({nm, " window"}, reg_data_out, ew);
            chk({nm, " data_done"}, 32'(mc_data_done), 32'(edd));
        end
        drive(COND_PROC, 1'b0, 8'h00, 7'd0);
        tick;
        chk({nm, " pulse end"}, 32'(mc_done), 32'd0);
    endtask

    initial begin
        logic [31:0] ew;
        vec_t        vr;

        // Store 6 then two loads; then gapped store of 3 and its load.
        add(3'b100, 1, 8'h10, 7'd6, 0, 0, 0, 32'h0);
        add(3'b100, 1, 8'h11, 7'd6, 0, 0, 0, 32'h0);
        add(3'b100, 1, 8'h12, 7'd6, 0, 0, 0, 32'h0);
        add(3'b100, 1, 8'h13, 7'd6, 0, 0, 0, 32'h0);
        add(3'b100, 1, 8'h14, 7'd6, 0, 0, 0, 32'h0);
        add(3'b100, 1, 8'h15, 7'd6, 1, 0, 0, 32'h0);
        add(3'b100, 0, 8'h00, 7'd6, 0, 0, 0, 32'h0);
        add(3'b010, 0, 8'h00, 7'd0, 0, 0, 0, 32'h0);
        add(3'b010, 0, 8'h00, 7'd0, 0, 0, 0, 32'h0);
        add(3'b010, 0, 8'h00, 7'd0, 0, 0, 0, 32'h00000010);
        add(3'b010, 0, 8'h00, 7'd0, 0, 0, 0, 32'h00001110);
        add(3'b010, 0, 8'h00, 7'd0, 0, 0, 0, 32'h00121110);
        add(3'b010, 0, 8'h00, 7'd0, 1, 0, 1, 32'h13121110);
        add(3'b010, 0, 8'h00, 7'd0, 0, 0, 1, 32'h13121110);
        add(3'b001, 0, 8'h00, 7'd0, 0, 0, 1, 32'h13121110);
        add(3'b010, 0, 8'h00, 7'd0, 0, 0, 0, 32'h0);
        add(3'b010, 0, 8'h00, 7'd0, 0, 0, 0, 32'h0);
        add(3'b010, 0, 8'h00, 7'd0, 0, 0, 0, 32'h00000014);
        add(3'b010, 0, 8'h00, 7'd0, 1, 1, 1, 32'h00001514);
        add(3'b010, 0, 8'h00, 7'd0, 0, 1, 1, 32'h00001514);
        add(3'b100, 1, 8'hA0, 7'd3, 0, 0, 0, 32'h00001514);
        add(3'b100, 0, 8'h55, 7'd3, 0, 0, 0, 32'h00001514);
        add(3'b100, 1, 8'hA1, 7'd3, 0, 0, 0, 32'h00001514);
        add(3'b100, 0, 8'h55, 7'd3, 0, 0, 0, 32'h00001514);
        add(3'b100, 1, 8'hA2, 7'd3, 1, 0, 0, 32'h00001514);
        add(3'b100, 1, 8'hFF, 7'd3, 0, 0, 0, 32'h00001514);
        add(3'b010, 0, 8'h00, 7'd0, 0, 0, 0, 32'h0);
        add(3'b010, 0, 8'h00, 7'd0, 0, 0, 0, 32'h0);
        add(3'b010, 0, 8'h00, 7'd0, 0, 0, 0, 32'h000000A0);
        add(3'b010, 0, 8'h00, 7'd0, 0, 0, 0, 32'h0000A1A0);
        add(3'b010, 0, 8'h00, 7'd0, 1, 1, 1, 32'h00A2A1A0);
        add(3'b001, 0, 8'h00, 7'd0, 0, 1, 1, 32'h00A2A1A0);

        // Reset state, checked while reset is held and after release.
        #12;
        chk("rst done", 32'(mc_done), 32'd0);
        chk("rst data_done", 32'(mc_data_done), 32'd0);
        chk("rst valid", 32'(reg_valid), 32'd0);
        chk("rst window", reg_data_out, 32'd0);
        #5 ctrl_reset = 1'b0;
        tick;
        chk("post-rst done", 32'(mc_done), 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            vr = vecs[i];
            drive(vr.c, vr.v, vr.d, vr.l);
            tick;
            chk($sformatf("vec%0d done", i), 32'(mc_done), 32'(vr.e_done));
            chk($sformatf("vec%0d data_done", i), 32'(mc_data_done), 32'(vr.e_dd));
            chk($sformatf("vec%0d valid", i), 32'(reg_valid), 32'(vr.e_rv));
            chk($sformatf("vec%0d window", i), reg_data_out, vr.e_win);
        end

        // Exact multiple of the window size.
        store_block(8, 8'h20, "len8");
        do_load(4, 32'h23222120, 1'b0, "len8 ld1");
        do_load(4, 32'h27262524, 1'b1, "len8 ld2");
        do_load(0, 32'h0, 1'b1, "len8 ld3");

        // Zero length.
        store_block(0, 8'h00, "len0");
        do_load(0, 32'h0, 1'b1, "len0 ld");

        // Full memory: word i holds 0x80+i.
        store_block(64, 8'h80, "len64");
        for (int n = 0; n < 16; n++) begin
            for (int j = 0; j < 4; j++) begin
                ew[j*8 +: 8] = 8'h80 + 8'(4 * n + j);
            end
            do_load(4, ew, (n == 15), $sformatf("len64 ld%0d", n));
        end

        // Abort after 2 of 5 words, then a fresh store from address 0.
        drive(COND_STORE, 1'b1, 8'h30, 7'd5);
        tick;
        drive(COND_STORE, 1'b1, 8'h31, 7'd5);
        tick;
        chk("abort pre done", 32'(mc_done), 32'd0);
        drive(COND_IDLE, 1'b1, 8'h32, 7'd5);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk($sformatf("abort done %0d", i), 32'(mc_done), 32'd0);
        end
        store_block(2, 8'h40, "restart");
        do_load(2, 32'h00004140, 1'b1, "restart ld");

        // Illegal code 110 mid-store: no writes, window untouched.
        drive(COND_STORE, 1'b1, 8'h60, 7'd4);
        tick;
        drive(COND_STORE, 1'b1, 8'h61, 7'd4);
        tick;
        drive(3'b110, 1'b1, 8'h77, 7'd4);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk($sformatf("illegal done %0d", i), 32'(mc_done), 32'd0);
            chk($sformatf("illegal window %0d", i), reg_data_out, 32'h00004140);
        end
        do_load(4, 32'h83826160, 1'b1, "illegal ld");

        // Asynchronous reset in the middle of a load.
        store_block(4, 8'h90, "rstld");
        drive(COND_TRANS, 1'b0, 8'h00, 7'd0);
        tick;
        tick;
        tick;
        chk("rstld partial window", reg_data_out, 32'h00000090);
        #2 ctrl_reset = 1'b1;
        #1;
        chk("rstld done", 32'(mc_done), 32'd0);
        chk("rstld data_done", 32'(mc_data_done), 32'd0);
        chk("rstld valid", 32'(reg_valid), 32'd0);
        chk("rstld window", reg_data_out, 32'd0);
        drive(COND_IDLE, 1'b0, 8'h00, 7'd0);
        #3 ctrl_reset = 1'b0;
        tick;
        chk("rstld after done", 32'(mc_done), 32'd0);
        chk("rstld after window", reg_data_out, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
